// File: rtl/am_score_tally.sv
// am_score_tally: per-class sparse overlap scoring, argmax inference and
// accuracy tallying for the associative-memory query sequencer.
// Each compare cycle adds popcount(query_seg & class_seg[c]) to every class
// score; the infer strobe latches the best class; the tally strobe updates
// saturating correct/total counters against the true label.
module am_score_tally #(
    parameter  int NUM_CLASSES     = 26,
    parameter  int SEG_WIDTH       = 64,
    parameter  int SEQ_CYCLE_COUNT = 10,
    parameter  int ACC_W           = 16,
    localparam int SCORE_W         = $clog2(SEG_WIDTH*SEQ_CYCLE_COUNT+1),
    localparam int CLS_W           = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           en,
    input  logic                           comparing_query_hv_with_class_hv,
    input  logic                           inferring_class,
    input  logic                           tallying_accuracy,
    input  logic [3:0]                     query_ctr,
    input  logic [SEG_WIDTH-1:0]           query_seg,
    input  logic [NUM_CLASSES*SEG_WIDTH-1:0] class_segs,
    input  logic [CLS_W-1:0]               true_label,
    input  logic                           clear_tally,
    output logic [CLS_W-1:0]               predicted_class,
    output logic [SCORE_W-1:0]             max_score,
    output logic                           prediction_valid,
    output logic [ACC_W-1:0]               correct_count,
    output logic [ACC_W-1:0]               total_count
);

    localparam logic [ACC_W-1:0]   ACC_MAX = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0]   ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [SCORE_W-1:0] SCORE_ZERO = {SCORE_W{1'b0}};

    // Number of bit positions set in both a and b; fits SCORE_W by construction.
    function automatic logic [SCORE_W-1:0] overlap_count(
        input logic [SEG_WIDTH-1:0] a,
        input logic [SEG_WIDTH-1:0] b
    );
        logic [SCORE_W-1:0] cnt;
        cnt = SCORE_ZERO;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            cnt = cnt + {{(SCORE_W-1){1'b0}}, (a[i] & b[i])};
        end
        return cnt;
    endfunction

    // Saturating increment for the accuracy counters.
    function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] r;
        if (v == ACC_MAX) begin
            r = v;
        end else begin
            r = v + ACC_ONE;
        end
        return r;
    endfunction

    logic [SCORE_W-1:0] score_r [NUM_CLASSES];
    logic [SCORE_W-1:0] ov_s    [NUM_CLASSES];
    logic [CLS_W-1:0]   predicted_class_r;
    logic [SCORE_W-1:0] max_score_r;
    logic               prediction_valid_r;
    logic [ACC_W-1:0]   correct_count_r;
    logic [ACC_W-1:0]   total_count_r;

    logic               cmp_act_s;
    logic               inf_act_s;
    logic               tal_act_s;
    logic               ctr_in_range_s;
    logic               ctr_first_s;
    logic [CLS_W-1:0]   best_idx_s;
    logic [SCORE_W-1:0] best_score_s;
    logic [ACC_W-1:0]   correct_nxt_s;
    logic [ACC_W-1:0]   total_nxt_s;

    // Strobes are one-hot in normal use; if several arrive, compare wins, then infer, then tally.
    always_comb begin
        cmp_act_s      = comparing_query_hv_with_class_hv;
        inf_act_s      = inferring_class & ~comparing_query_hv_with_class_hv;
        tal_act_s      = tallying_accuracy & ~comparing_query_hv_with_class_hv & ~inferring_class;
        ctr_in_range_s = ({28'd0, query_ctr} < 32'(SEQ_CYCLE_COUNT));
        ctr_first_s    = (query_ctr == 4'd0);
    end

    // Per-class overlap of the current query segment with each class segment.
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            ov_s[c] = overlap_count(query_seg, class_segs[c*SEG_WIDTH +: SEG_WIDTH]);
        end
    end

    // Score accumulation: segment 0 overwrites (new query), later segments add.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                score_r[c] <= SCORE_ZERO;
            end
        end else if (en && cmp_act_s && ctr_in_range_s) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (ctr_first_s) begin
                    score_r[c] <= ov_s[c];
                end else begin
                    score_r[c] <= score_r[c] + ov_s[c];
                end
            end
        end
    end

    // Argmax over registered scores; strict '>' keeps the lowest index on ties.
    always_comb begin
        best_idx_s   = {CLS_W{1'b0}};
        best_score_s = score_r[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (score_r[c] > best_score_s) begin
                best_idx_s   = CLS_W'(c);
                best_score_s = score_r[c];
            end else begin
                best_idx_s   = best_idx_s;
                best_score_s = best_score_s;
            end
        end
    end

    // Latch the inference result; scores are left intact for inspection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            predicted_class_r <= {CLS_W{1'b0}};
            max_score_r       <= SCORE_ZERO;
        end else if (en && inf_act_s) begin
            predicted_class_r <= best_idx_s;
            max_score_r       <= best_score_s;
        end
    end

    // Next accuracy counter values; clear beats a simultaneous tally.
    always_comb begin
        correct_nxt_s = correct_count_r;
        total_nxt_s   = total_count_r;
        if (clear_tally) begin
            correct_nxt_s = {ACC_W{1'b0}};
            total_nxt_s   = {ACC_W{1'b0}};
        end else if (tal_act_s) begin
            total_nxt_s = sat_inc(total_count_r);
            if (predicted_class_r == true_label) begin
                correct_nxt_s = sat_inc(correct_count_r);
            end else begin
                correct_nxt_s = correct_count_r;
            end
        end else begin
            correct_nxt_s = correct_count_r;
            total_nxt_s   = total_count_r;
        end
    end

    // Accuracy counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            correct_count_r <= {ACC_W{1'b0}};
            total_count_r   <= {ACC_W{1'b0}};
        end else if (en) begin
            correct_count_r <= correct_nxt_s;
            total_count_r   <= total_nxt_s;
        end
    end

    // One-cycle valid pulse following each tally strobe; dropped while disabled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prediction_valid_r <= 1'b0;
        end else if (en) begin
            prediction_valid_r <= tal_act_s;
        end else begin
            prediction_valid_r <= 1'b0;
        end
    end

    assign predicted_class  = predicted_class_r;
    assign max_score        = max_score_r;
    assign prediction_valid = prediction_valid_r;
    assign correct_count    = correct_count_r;
    assign total_count      = total_count_r;

endmodule
